neopix_frame_fetch: RTL and testbench

Frame-fetch controller sitting between the 512×32 pixel frame-buffer RAM and the NeoPixel bit serializer. On a start request it sequences reads of `pixel_count` consecutive words starting at `base_addr`, absorbs the RAM's two-cycle read latency in a 4-entry credit-controlled FIFO, and presents pixels to the serializer over a valid/ready handshake. After the last pixel is accepted it holds a latch (reset-low) gap before reporting frame completion.

---
 rtl/neopix_frame_fetch.sv | 243 ++++++++++++++++++++++++
 tb/tb_neopix_frame_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopix_frame_fetch.sv
// Frame-fetch controller: reads a pixel run from the frame-buffer RAM into a small FIFO feeding the serializer.
// Optional build macro NEOPIX_FRAME_REPEAT_EN enables auto-repeat of frames and adds the 'stop' input.
module neopix_frame_fetch #(
    parameter int ADDR_W       = 9,
    parameter int FIFO_DEPTH   = 4,
    parameter int LATCH_CYCLES = 3000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   pixel_count,
`ifdef NEOPIX_FRAME_REPEAT_EN
    input  logic              stop,
`endif
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [31:0]       rd_data,
    output logic [23:0]       pixel_data,
    output logic              pixel_valid,
    input  logic              pixel_ready,
    output logic              busy,
    output logic              latch_active,
    output logic              frame_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [LAT_W-1:0]  LATCH_LOAD = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_ONE    = LAT_W'(1);
    localparam logic [ADDR_W:0]   PIX_ONE    = (ADDR_W+1)'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, LATCH} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_W-1:0]               base_q, base_d;
    logic [ADDR_W:0]                 count_q, count_d;
    logic [ADDR_W:0]                 issued_q, issued_d;
    logic [ADDR_W:0]                 accepted_q, accepted_d;
    logic [LAT_W-1:0]                latch_cnt_q, latch_cnt_d;
    logic [ADDR_W-1:0]               rdaddress_q, rdaddress_d;
    logic                            iss_q, iss_d;
    logic                            s1_q, s1_d;
    logic                            s2_q, s2_d;
    logic [CNT_W-1:0]                outstanding_q, outstanding_d;
    logic [CNT_W-1:0]                fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH-1:0][23:0]     mem_q, mem_d;
    logic [23:0]                     pixel_data_q, pixel_data_d;
    logic                            pixel_valid_q, pixel_valid_d;
    logic                            busy_q, busy_d;
    logic                            latch_active_q, latch_active_d;
    logic                            frame_done_q, frame_done_d;
`ifdef NEOPIX_FRAME_REPEAT_EN
    logic                            stop_req_q, stop_req_d;
`endif
    logic                            issue;
    logic                            pop;
    logic                            push;
    logic                            credit_ok;
    logic                            unused_rd_msbs;

    assign unused_rd_msbs = ^rd_data[31:24];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // outstanding counts FIFO entries plus reads in flight; a same-cycle pop frees its credit immediately
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        issued_d    = issued_q;
        latch_cnt_d = latch_cnt_q;
        rdaddress_d = rdaddress_q;
        frame_done_d = 1'b0;
        issue       = 1'b0;
        pop         = pixel_valid_q && pixel_ready;
        push        = s2_q;
        credit_ok   = (outstanding_q < DEPTH_C) || pop;
        accepted_d  = accepted_q + {{ADDR_W{1'b0}}, pop};

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    count_d    = pixel_count;
                    issued_d   = '0;
                    accepted_d = '0;
                    if (pixel_count == '0) begin
                        state_d     = LATCH;
                        latch_cnt_d = LATCH_LOAD;
                    end else begin
                        issue       = 1'b1;
                        rdaddress_d = base_addr;
                        issued_d    = PIX_ONE;
                        state_d     = FETCH;
                    end
                end
            end
            FETCH: begin
                if (issued_q == count_q) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    issue       = 1'b1;
                    rdaddress_d = base_q + issued_q[ADDR_W-1:0];
                    issued_d    = issued_q + PIX_ONE;
                end
            end
            DRAIN: begin
                if (accepted_d == count_q) begin
                    state_d     = LATCH;
                    latch_cnt_d = LATCH_LOAD;
                end
            end
            LATCH: begin
                if (latch_cnt_q == '0) begin
                    frame_done_d = 1'b1;
`ifdef NEOPIX_FRAME_REPEAT_EN
                    if (stop_req_q || stop) begin
                        state_d = IDLE;
                    end else begin
                        issued_d   = '0;
                        accepted_d = '0;
                        if (count_q == '0) begin
                            state_d     = LATCH;
                            latch_cnt_d = LATCH_LOAD;
                        end else begin
                            state_d = FETCH;
                        end
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    latch_cnt_d = latch_cnt_q - LAT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef NEOPIX_FRAME_REPEAT_EN
        stop_req_d = (state_d == IDLE) ? 1'b0 : (stop_req_q | stop);
`endif

        iss_d = issue;
        s1_d  = iss_q;
        s2_d  = s1_q;

        case ({issue, pop})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = rd_data[23:0];
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
            2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase

        pixel_valid_d  = (fifo_count_d != '0);
        pixel_data_d   = (fifo_count_d != '0) ? mem_d[rd_ptr_d] : pixel_data_q;
        busy_d         = (state_d != IDLE);
        latch_active_d = (state_d == LATCH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            base_q         <= '0;
            count_q        <= '0;
            issued_q       <= '0;
            accepted_q     <= '0;
            latch_cnt_q    <= '0;
            rdaddress_q    <= '0;
            iss_q          <= 1'b0;
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            outstanding_q  <= '0;
            fifo_count_q   <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            mem_q          <= '0;
            pixel_data_q   <= '0;
            pixel_valid_q  <= 1'b0;
            busy_q         <= 1'b0;
            latch_active_q <= 1'b0;
            frame_done_q   <= 1'b0;
`ifdef NEOPIX_FRAME_REPEAT_EN
            stop_req_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            count_q        <= count_d;
            issued_q       <= issued_d;
            accepted_q     <= accepted_d;
            latch_cnt_q    <= latch_cnt_d;
            rdaddress_q    <= rdaddress_d;
            iss_q          <= iss_d;
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            outstanding_q  <= outstanding_d;
            fifo_count_q   <= fifo_count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            mem_q          <= mem_d;
            pixel_data_q   <= pixel_data_d;
            pixel_valid_q  <= pixel_valid_d;
            busy_q         <= busy_d;
            latch_active_q <= latch_active_d;
            frame_done_q   <= frame_done_d;
`ifdef NEOPIX_FRAME_REPEAT_EN
            stop_req_q     <= stop_req_d;
`endif
        end
    end

    assign rdaddress    = rdaddress_q;
    assign pixel_data   = pixel_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign busy         = busy_q;
    assign latch_active = latch_active_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_neopix_frame_fetch.sv
// Bench for neopix_frame_fetch: a two-cycle-latency RAM model feeds the DUT and a queue of
// expected pixels, derived from the frame parameters, scores every accepted pixel and frame timing.
module tb_neopix_frame_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  pixel_count;
    logic [8:0]  rdaddress;
    logic [31:0] rd_data;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        busy;
    logic        latch_active;
    logic        frame_done;
`ifdef NEOPIX_FRAME_REPEAT_EN
    logic        stop;
`endif

    logic [31:0] ram [0:511];
    logic [31:0] ramStage;

    int vectors = 0;
    int miscompares = 0;

    neopix_frame_fetch #(
        .ADDR_W(9),
        .FIFO_DEPTH(4),
        .LATCH_CYCLES(3000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .pixel_count(pixel_count),
`ifdef NEOPIX_FRAME_REPEAT_EN
        .stop(stop),
`endif
        .rdaddress(rdaddress),
        .rd_data(rd_data),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .busy(busy),
        .latch_active(latch_active),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // Frame-buffer RAM: data appears two clocks after the address
    always @(posedge clock) begin
        ramStage <= ram[rdaddress];
        rd_data  <= ramStage;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic readyFor(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    // One complete frame: mode 0 = ready always high, 1 = ready one cycle in three, 2 = random ready
    task automatic applyStimulus(input int base, input int count, input int mode);
        logic [23:0] expQ[$];
        logic [31:0] word;
        logic [8:0]  prevAddr;
        logic [8:0]  addrBefore;
        int seen = 0;
        int accepted = 0;
        int latchN = 0;
        int doneCyc = -1;
        int firstValid = -1;
        int lastAcc = -1;
        int maxOcc = 0;
        int bound;
        bit finished = 0;

        for (int i = 0; i < count; i++) begin
            word = ram[(base + i) % 512];
            expQ.push_back(word[23:0]);
        end
        bound = count * 4 + 3100;

        @(negedge clock);
        addrBefore  = rdaddress;
        prevAddr    = rdaddress;
        start       = 1'b1;
        base_addr   = 9'(base);
        pixel_count = 10'(count);
        @(posedge clock);
        #1;
        start       = 1'b0;
        pixel_ready = readyFor(mode, 1);

        for (int cyc = 1; cyc <= bound && !finished; cyc++) begin
            @(negedge clock);
            if (cyc == 1) checkOutput("busy_at_T1", 32'(busy), 1);
            if (cyc == 1 && count > 0) begin
                checkOutput("first_addr", 32'(rdaddress), 32'(base % 512));
                seen++;
                prevAddr = rdaddress;
            end else if (rdaddress != prevAddr) begin
                if (count == 0) checkOutput("addr_static", 32'(rdaddress), 32'(addrBefore));
                else checkOutput("addr_seq", 32'(rdaddress), 32'((base + seen) % 512));
                seen++;
                prevAddr = rdaddress;
            end
            if (seen - accepted > maxOcc) maxOcc = seen - accepted;
            if (pixel_valid && firstValid < 0) firstValid = cyc;
            if (pixel_valid && pixel_ready) begin
                if (expQ.size() == 0) checkOutput("extra_pixel", 1, 0);
                else checkOutput("pixel", 32'(pixel_data), 32'(expQ.pop_front()));
                accepted++;
                lastAcc = cyc;
            end
            if (latch_active) latchN++;
            if (frame_done) begin
                doneCyc  = cyc;
                finished = 1;
                checkOutput("busy_at_done", 32'(busy), 0);
            end else begin
                @(posedge clock);
                #1;
                pixel_ready = readyFor(mode, cyc + 1);
            end
        end

        if (!finished) checkOutput("frame_timeout", 0, 1);
        checkOutput("pixels_accepted", accepted, count);
        checkOutput("latch_len", latchN, 3000);
        checkOutput("occupancy_le_4", 32'(maxOcc <= 4), 1);
        if (count > 0) begin
            checkOutput("first_valid_cyc", firstValid, 4);
            checkOutput("done_after_last", doneCyc, lastAcc + 3001);
        end else begin
            checkOutput("done_cyc_empty", doneCyc, 3001);
            checkOutput("addr_hold", 32'(rdaddress), 32'(addrBefore));
        end
        if (mode == 0 && count > 0) checkOutput("frame_duration", doneCyc, count + 3004);
        @(negedge clock);
        checkOutput("done_single_pulse", 32'(frame_done), 0);
        pixel_ready = 1'b0;
    endtask

    // Reset in the middle of a fetching frame must drop everything in flight
    task automatic midResetTest();
        logic [31:0] word;
        int acc = 0;
        int noisy = 0;

        @(negedge clock);
        start       = 1'b1;
        base_addr   = 9'd100;
        pixel_count = 10'd20;
        pixel_ready = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 20 && acc < 3; cyc++) begin
            @(negedge clock);
            if (pixel_valid && pixel_ready) begin
                word = ram[100 + acc];
                checkOutput("rst_pixel", 32'(pixel_data), 32'(word[23:0]));
                acc++;
            end
        end
        checkOutput("rst_pre_pixels", acc, 3);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_valid", 32'(pixel_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_addr", 32'(rdaddress), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (pixel_valid || busy) noisy++;
        end
        checkOutput("rst_quiet", noisy, 0);
        pixel_ready = 1'b0;
    endtask

`ifdef NEOPIX_FRAME_REPEAT_EN
    task automatic repeatTest();
        int pulses = 0;
        int accepted = 0;
        bit finished = 0;

        stop = 1'b0;
        @(negedge clock);
        start       = 1'b1;
        base_addr   = 9'd10;
        pixel_count = 10'd2;
        pixel_ready = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 9300 && !finished; cyc++) begin
            @(negedge clock);
            if (pixel_valid && pixel_ready) accepted++;
            if (frame_done) begin
                pulses++;
                if (pulses == 2) begin
                    checkOutput("repeat_busy", 32'(busy), 1);
                    stop = 1'b1;
                end
                if (pulses == 3) begin
                    checkOutput("repeat_stop_idle", 32'(busy), 0);
                    finished = 1;
                end
            end
        end
        checkOutput("repeat_pulses", pulses, 3);
        checkOutput("repeat_pixels", accepted, 6);
        pixel_ready = 1'b0;
    endtask
`endif

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        pixel_count = '0;
        pixel_ready = 1'b0;
`ifdef NEOPIX_FRAME_REPEAT_EN
        stop        = 1'b1;
`endif
        for (int i = 0; i < 512; i++) ram[i] = 32'(i);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_rdaddress", 32'(rdaddress), 0);
        checkOutput("reset_valid", 32'(pixel_valid), 0);
        checkOutput("reset_data", 32'(pixel_data), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_latch", 32'(latch_active), 0);
        checkOutput("reset_done", 32'(frame_done), 0);

        applyStimulus(0, 8, 0);
        applyStimulus(508, 6, 0);

        for (int i = 0; i < 512; i++) ram[i] = $urandom;
        applyStimulus(int'($urandom_range(0, 511)), 16, 1);
        applyStimulus(37, 0, 0);
        midResetTest();
        applyStimulus(200, 5, 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(int'($urandom_range(0, 511)), int'($urandom_range(1, 40)), 2);
        end
        applyStimulus(int'($urandom_range(0, 511)), 512, 2);
`ifdef NEOPIX_FRAME_REPEAT_EN
        repeatTest();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
